// File: rtl/display_pkg.sv
// Shared constants for the game status display: channel ids,
// default channel masks and timing defaults.
package display_pkg;

  localparam int DEF_N_MSG = 11;

  typedef enum int {
    BLACK_PLAY   = 0,
    WHITE_PLAY   = 1,
    BLACK_WIN    = 2,
    WHITE_WIN    = 3,
    DRAW         = 4,
    ILLEGAL_MOVE = 5,
    CHECK        = 6,
    PASS_MOVE    = 7,
    YOUR_TURN    = 8,
    GAME_OVER    = 9,
    NO_MOVE      = 10
  } msg_id_e;

  localparam logic [31:0] DEF_TURN_MASK    = 32'h003;
  localparam logic [31:0] DEF_ACK_MASK     = 32'h5E0;
  localparam logic [31:0] DEF_NEWGAME_MASK = 32'h21C;
  localparam logic [31:0] DEF_EXPIRE_MASK  = 32'h400;
  localparam logic [31:0] DEF_BLINK_MASK   = 32'h100;

  localparam int DEF_EXPIRE_CYC = 100_000_000;
  localparam int DEF_BLINK_HALF = 25_000_000;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/expire_timer.sv
// Lifetime counter for one auto-expiring channel; held at zero
// while the channel is idle, restarted by start.
module expire_timer
  import display_pkg::*;
#(
  parameter int LIFE = DEF_EXPIRE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int W = cnt_w(LIFE);
  localparam logic [W-1:0] LAST = W'(LIFE - 1);

  logic [W-1:0] cnt;

  assign expired = !clear && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (start || clear || expired)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/status_display_ctrl.sv
// Sticky status flags with turn exclusivity, ack/new-game clears,
// auto-expiry, blinking and a highest-index priority encoder.
module status_display_ctrl
  import display_pkg::*;
#(
  parameter int          N_MSG        = DEF_N_MSG,
  parameter logic [31:0] TURN_MASK    = DEF_TURN_MASK,
  parameter logic [31:0] ACK_MASK     = DEF_ACK_MASK,
  parameter logic [31:0] NEWGAME_MASK = DEF_NEWGAME_MASK,
  parameter logic [31:0] EXPIRE_MASK  = DEF_EXPIRE_MASK,
  parameter int          EXPIRE_CYC   = DEF_EXPIRE_CYC,
  parameter logic [31:0] BLINK_MASK   = DEF_BLINK_MASK,
  parameter int          BLINK_HALF   = DEF_BLINK_HALF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_MSG-1:0]         set,
  input  logic                     ack,
  input  logic                     new_game,
  output logic [N_MSG-1:0]         active,
  output logic [N_MSG-1:0]         display,
  output logic                     top_valid,
  output logic [$clog2(N_MSG)-1:0] top_id
);

  localparam int IW = $clog2(N_MSG);
  localparam int BW = cnt_w(BLINK_HALF);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_HALF - 1);

  localparam logic [N_MSG-1:0] TM = TURN_MASK[N_MSG-1:0];
  localparam logic [N_MSG-1:0] AM = ACK_MASK[N_MSG-1:0];
  localparam logic [N_MSG-1:0] NM = NEWGAME_MASK[N_MSG-1:0];
  localparam logic [N_MSG-1:0] EM = EXPIRE_MASK[N_MSG-1:0];
  localparam logic [N_MSG-1:0] BM = BLINK_MASK[N_MSG-1:0];

  logic [N_MSG-1:0] set_turn;
  logic [N_MSG-1:0] turn_hi;
  logic [N_MSG-1:0] turn_clr;
  logic [N_MSG-1:0] set_eff;
  logic [N_MSG-1:0] clr;
  logic [N_MSG-1:0] expired;
  logic [N_MSG-1:0] active_d;
  logic [N_MSG-1:0] rise;
  logic [BW-1:0]    blink_cnt;
  logic             phase;

  // Only the highest-index turn set survives; it evicts the rest.
  always_comb begin
    set_turn = set & TM;
    turn_hi  = '0;
    for (int i = 0; i < N_MSG; i++) begin
      if (set_turn[i]) begin
        turn_hi    = '0;
        turn_hi[i] = 1'b1;
      end
    end
    turn_clr = (|set_turn) ? (TM & ~turn_hi) : '0;
    set_eff  = (set & ~TM) | turn_hi;
  end

  assign clr = ({N_MSG{new_game}} & NM) | ({N_MSG{ack}} & AM);

  assign active_d = ~clr
                  & (set_eff | (active & ~turn_clr & ~expired));

  assign rise = active_d & ~active & BM;

  for (genvar i = 0; i < N_MSG; i++) begin : g_exp
    if (EM[i]) begin : g_tmr
      expire_timer #(
        .LIFE(EXPIRE_CYC)
      ) u_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (set_eff[i] & ~clr[i]),
        .clear  (~active[i]),
        .expired(expired[i])
      );
    end else begin : g_none
      assign expired[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      active <= '0;
    else
      active <= active_d;
  end

  // A freshly raised blinking flag always starts in the visible phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (|rise) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == B_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign display = active & (~BM | {N_MSG{phase}});

  assign top_valid = |active;

  always_comb begin
    top_id = '0;
    for (int i = 0; i < N_MSG; i++) begin
      if (active[i])
        top_id = IW'(i);
    end
  end

endmodule

// File: tb/tb_status_display_ctrl.sv
// Directed table plus multi-cycle sequences for status_display_ctrl
// with EXPIRE_CYC=8 and BLINK_HALF=4.
module tb_status_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] set;
  logic        ack;
  logic        new_game;
  logic [10:0] active;
  logic [10:0] display;
  logic        top_valid;
  logic [3:0]  top_id;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  status_display_ctrl #(
    .EXPIRE_CYC(8),
    .BLINK_HALF(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set      (set),
    .ack      (ack),
    .new_game (new_game),
    .active   (active),
    .display  (display),
    .top_valid(top_valid),
    .top_id   (top_id)
  );

  typedef struct {
    logic        r;
    logic [10:0] s;
    logic        a;
    logic        g;
    logic [10:0] act;
    logic        tv;
    logic [3:0]  id;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [10:0] s,
                     input logic a, input logic g);
    rst_n    = r;
    set      = s;
    ack      = a;
    new_game = g;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    set      = '0;
    ack      = 1'b0;
    new_game = 1'b0;
  endtask

  task automatic chk_all(input string nm, input logic [10:0] a,
                         input logic [10:0] d, input logic tv,
                         input logic [3:0] id);
    chk({nm, ".active"}, 16'(active), 16'(a));
    chk({nm, ".display"}, 16'(display), 16'(d));
    chk({nm, ".top"}, {11'd0, top_valid, top_id}, {11'd0, tv, id});
  endtask

  initial begin
    rst_n    = 1'b0;
    set      = '0;
    ack      = 1'b0;
    new_game = 1'b0;

    tbl[0]  = '{1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, 11'h7FF, 1'b0, 1'b0, 11'h000, 1'b0, 4'd0};
    tbl[2]  = '{1'b1, 11'h001, 1'b0, 1'b0, 11'h001, 1'b1, 4'd0};
    tbl[3]  = '{1'b1, 11'h002, 1'b0, 1'b0, 11'h002, 1'b1, 4'd1};
    tbl[4]  = '{1'b1, 11'h003, 1'b0, 1'b0, 11'h002, 1'b1, 4'd1};
    tbl[5]  = '{1'b1, 11'h020, 1'b1, 1'b0, 11'h002, 1'b1, 4'd1};
    tbl[6]  = '{1'b1, 11'h020, 1'b0, 1'b0, 11'h022, 1'b1, 4'd5};
    tbl[7]  = '{1'b1, 11'h000, 1'b1, 1'b0, 11'h002, 1'b1, 4'd1};
    tbl[8]  = '{1'b1, 11'h01C, 1'b0, 1'b0, 11'h01E, 1'b1, 4'd4};
    tbl[9]  = '{1'b1, 11'h001, 1'b0, 1'b0, 11'h01D, 1'b1, 4'd4};
    tbl[10] = '{1'b1, 11'h004, 1'b0, 1'b1, 11'h001, 1'b1, 4'd0};
    tbl[11] = '{1'b1, 11'h200, 1'b1, 1'b0, 11'h201, 1'b1, 4'd9};
    tbl[12] = '{1'b1, 11'h000, 1'b0, 1'b1, 11'h001, 1'b1, 4'd0};
    tbl[13] = '{1'b1, 11'h002, 1'b0, 1'b0, 11'h002, 1'b1, 4'd1};

    @(negedge clk);
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].g);
      chk_all($sformatf("tbl%0d", i), tbl[i].act, tbl[i].act,
              tbl[i].tv, tbl[i].id);
    end

    // expiry: high for 8 edges, low at the 9th
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 11'h400, 1'b0, 1'b0);
    chk("exp0", 16'(active), 16'h400);
    for (int e = 1; e <= 8; e++) begin
      cyc(1'b1, '0, 1'b0, 1'b0);
      chk($sformatf("exp%0d", e), 16'(active),
          (e < 8) ? 16'h400 : 16'h000);
    end

    // re-set at k+5 pushes expiry to k+13
    cyc(1'b1, 11'h400, 1'b0, 1'b0);
    for (int e = 1; e <= 13; e++) begin
      cyc(1'b1, (e == 5) ? 11'h400 : 11'h000, 1'b0, 1'b0);
      chk($sformatf("rexp%0d", e), 16'(active),
          (e < 13) ? 16'h400 : 16'h000);
    end

    cyc(1'b1, 11'h400, 1'b0, 1'b0);
    cyc(1'b1, '0, 1'b1, 1'b0);
    chk("exp_ack", 16'(active), 16'h000);

    // reset mid-expiry leaves nothing behind
    cyc(1'b1, 11'h400, 1'b0, 1'b0);
    for (int e = 0; e < 3; e++) cyc(1'b1, '0, 1'b0, 1'b0);
    cyc(1'b0, 11'h400, 1'b0, 1'b0);
    chk_all("exp_rst", '0, '0, 1'b0, 4'd0);
    cyc(1'b1, 11'h400, 1'b0, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      cyc(1'b1, '0, 1'b0, 1'b0);
      chk($sformatf("exp_fresh%0d", e), 16'(active),
          (e < 8) ? 16'h400 : 16'h000);
    end

    // blink: 4 visible, 4 dark
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 11'h100, 1'b0, 1'b0);
    chk_all("blk0", 11'h100, 11'h100, 1'b1, 4'd8);
    for (int e = 1; e < 16; e++) begin
      cyc(1'b1, '0, 1'b0, 1'b0);
      chk($sformatf("blk%0d.display", e), 16'(display),
          (((e / 4) % 2) == 0) ? 16'h100 : 16'h000);
      chk($sformatf("blk%0d.active", e), 16'(active), 16'h100);
    end
    cyc(1'b1, '0, 1'b1, 1'b0);
    chk_all("blk_ack", '0, '0, 1'b0, 4'd0);

    // reset mid-blink, then a fresh set starts visible
    cyc(1'b1, 11'h100, 1'b0, 1'b0);
    for (int e = 0; e < 5; e++) cyc(1'b1, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk_all("blk_rst", '0, '0, 1'b0, 4'd0);
    cyc(1'b1, 11'h100, 1'b0, 1'b0);
    chk_all("blk_fresh", 11'h100, 11'h100, 1'b1, 4'd8);

    // new_game clears everything outside the turn group
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 11'h01C, 1'b0, 1'b0);
    chk_all("ng_set", 11'h01C, 11'h01C, 1'b1, 4'd4);
    cyc(1'b1, '0, 1'b0, 1'b1);
    chk_all("ng_clr", '0, '0, 1'b0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/status_display_ctrl.md
STATUS_DISPLAY_CTRL -- requirements
Module: status_display_ctrl

Interface
REQ-001 Parameter N_MSG, default 11: number of message channels.
REQ-002 Parameter TURN_MASK, default 11'h003: mutually exclusive group of channels.
REQ-003 Parameter ACK_MASK, default 11'h5E0: channels cleared by ack.
REQ-004 Parameter NEWGAME_MASK, default 11'h21C: channels cleared by new_game.
REQ-005 Parameter EXPIRE_MASK, default 11'h400: channels that auto-expire.
REQ-006 Parameter EXPIRE_CYC, default 100_000_000: auto-expire lifetime in cycles, minimum 2.
REQ-007 Parameter BLINK_MASK, default 11'h100: channels that blink.
REQ-008 Parameter BLINK_HALF, default 25_000_000: blink half-period in cycles, minimum 1.
REQ-009 Port clk, input, 1: single clock; all logic on posedge.
REQ-010 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-011 Port set, input, N_MSG: one-cycle set pulses, one per channel.
REQ-012 Port ack, input, 1: user-turn-done pulse.
REQ-013 Port new_game, input, 1: new-game pulse.
REQ-014 Port active, output, N_MSG: latched channel flags.
REQ-015 Port display, output, N_MSG: active gated by blink phase.
REQ-016 Port top_valid, output, 1: at least one channel is active.
REQ-017 Port top_id, output, $clog2(N_MSG): index of the highest-priority active channel.

Function
REQ-018 Each channel flag shall be a sticky register; a set pulse at edge k shall make active high from edge k onward (one-cycle latency).
REQ-019 Per-channel precedence, highest first, shall be: rst_n low; new_game (NEWGAME_MASK bits); ack (ACK_MASK bits); set; expiry; hold.
REQ-020 A clear (new_game or ack) coinciding with a set on the same channel shall win; the flag ends low.
REQ-021 A set on a TURN_MASK channel shall clear all other TURN_MASK channels in the same cycle.
REQ-022 Simultaneous sets on several TURN_MASK channels shall leave only the highest index set.
REQ-023 Each EXPIRE_MASK channel shall own a counter, zeroed on set, that increments while the flag is high.
REQ-024 The expiring flag shall clear at the edge where its counter reaches EXPIRE_CYC-1, i.e. EXPIRE_CYC cycles after being set.
REQ-025 A re-set while an expiring flag is high shall restart its counter.
REQ-026 Channels not in EXPIRE_MASK shall have no counter logic.
REQ-027 The blink counter shall run 0..BLINK_HALF-1 and toggle phase on wrap.
REQ-028 The blink counter shall restart, with phase=1, at any edge where a BLINK_MASK flag goes 0->1.
REQ-029 display[i] shall equal active[i] AND (NOT BLINK_MASK[i] OR phase), combinational from registers.
REQ-030 Priority shall increase with index; top_id shall be the highest active index; top_valid shall be the OR of active; top_id shall be 0 when top_valid=0.
REQ-031 Mask bits at or above N_MSG shall be ignored.

Reset
REQ-032 With rst_n low at an edge: active=0, display=0, top_valid=0, top_id=0, all expiry counters=0, blink counter=0, phase=1.
REQ-033 Reset asserted mid-expiry or mid-blink shall abort the operation with no residual state; set pulses are ignored while rst_n is low.

Structure
REQ-034 Default masks and channel index constants (BLACK_PLAY=0 .. NO_MOVE=10) shall live in shared package display_pkg.
REQ-035 The per-channel expiry counter shall be sub-module expire_timer (ports clk, rst_n, start, clear, expired), instantiated by generate for EXPIRE_MASK bits.

Verification (bench params: EXPIRE_CYC=8, BLINK_HALF=4)
REQ-036 Reset, then set=11'h001, then set=11'h002 one cycle later -> active=11'h002, top_id=1.
REQ-037 set=11'h020 together with ack=1 -> active[5]=0; set=11'h020 alone, then ack -> active[5]=1 then 0, and active[0] unchanged.
REQ-038 set=11'h400 at edge k -> active[10]=1 for edges k..k+7, then 0 at edge k+8; a re-set at k+5 extends expiry to k+13.
REQ-039 set=11'h100 -> display[8] high 4 cycles, low 4 cycles, repeating while active[8]=1; ack clears both.
REQ-040 active=11'h01C, then new_game=1 -> active=0, top_valid=0; rst_n low mid-blink -> all outputs 0 on the next edge.
